// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : riscv_mem_pkg                                                    |
// | Brief   : RV32I load/store funct3 codes, LSU state type and lane helpers.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } lsu_state_t;

  // Unsigned-load codes have no store counterpart, so they are errors on a store.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] lane);
    logic err;
    case (f3)
      F3_LB:   err = 1'b0;
      F3_LH:   err = lane[0];
      F3_LW:   err = |lane;
      F3_LBU:  err = we;
      F3_LHU:  err = we | lane[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic        is_half);
    logic [31:0] mask;
    mask = is_half ? 32'h0000_FFFF : 32'h0000_00FF;
    mask = mask << {lane, 3'b000};
    return (old_word & ~mask) | ((wdata << {lane, 3'b000}) & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : load_extend                                                      |
// | Brief   : Selects the addressed byte/half of a word and sign/zero extends. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module load_extend
  import riscv_mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic [1:0]       i_lane,
  input  logic [2:0]       i_funct3,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_shifted;

  assign w_shifted = i_word >> {i_lane, 3'b000};

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_LB:   o_data = {{(WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_data = {{(WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   o_data = i_word;
      F3_LBU:  o_data = {{(WIDTH-8){1'b0}}, w_shifted[7:0]};
      F3_LHU:  o_data = {{(WIDTH-16){1'b0}}, w_shifted[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : load_store_unit                                                  |
// | Brief   : MEM-stage LSU for a word-only memory; sub-word stores use RMW.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module load_store_unit
  import riscv_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [4:0]       req_rd,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rd,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [4:0]       rsp_rd,
  output logic             rsp_err
);

  lsu_state_t       r_state;
  lsu_state_t       w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] r_merged;
  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_load_data;
  logic             w_accept;
  logic             w_err;
  logic             w_is_load;
  logic             w_is_sw;
  logic             w_is_sub;
  logic             w_unused;

  // Upper address bits fall outside the memory and simply wrap.
  assign w_idx     = req_addr[IDX_W+1:2];
  assign w_unused  = &{1'b0, req_addr[WIDTH-1:IDX_W+2]};

  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid & req_ready;
  assign w_err     = access_err(req_we, req_funct3, req_addr[1:0]);
  assign w_is_load = w_accept & ~req_we & ~w_err;
  assign w_is_sw   = w_accept & req_we & ~w_err & (req_funct3 == F3_SW);
  assign w_is_sub  = w_accept & req_we & ~w_err & (req_funct3 != F3_SW);
  assign w_merged  = merge_store(mem_rd, req_wdata, req_addr[1:0], req_funct3 == F3_SH);

  load_extend #(
    .WIDTH(WIDTH)
  ) u_load_extend (
    .i_word  (mem_rd),
    .i_lane  (req_addr[1:0]),
    .i_funct3(req_funct3),
    .o_data  (w_load_data)
  );

  always_comb begin
    w_state_next = r_state;
    mem_we       = 1'b0;
    mem_wd       = req_wdata;
    mem_addr     = {{(WIDTH-IDX_W){1'b0}}, w_idx};
    case (r_state)
      ST_IDLE: begin
        mem_we = w_is_sw;
        if (w_is_sub) w_state_next = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        mem_we       = 1'b1;
        mem_wd       = r_merged;
        mem_addr     = {{(WIDTH-IDX_W){1'b0}}, r_idx};
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_merged  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_rd    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      rsp_valid <= w_accept & (w_err | ~req_we);
      rsp_err   <= w_accept & w_err;
      rsp_rdata <= w_is_load ? w_load_data : '0;
      rsp_rd    <= (w_accept & ~req_we) ? req_rd : '0;
      if (w_is_sub) begin
        r_idx    <= w_idx;
        r_merged <= w_merged;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_load_store_unit                                               |
// | Brief   : Directed + randomized bench for load_store_unit with a ref model.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;

  localparam int WIDTH = 32;
  localparam int IDX_W = 8;
  localparam int DEPTH = 256;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_we = 1'b0;
  logic [2:0]       req_funct3 = '0;
  logic [WIDTH-1:0] req_addr = '0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic [4:0]       req_rd = '0;
  logic             req_ready;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wd;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rd;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic [4:0]       rsp_rd;
  logic             rsp_err;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  // Word-wide data memory seen by the DUT
  logic [31:0] mem [DEPTH];
  assign mem_rd = mem_we ? 32'd0 : mem[mem_addr[IDX_W-1:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[IDX_W-1:0]] = mem_wd;

  // Reference model state
  typedef struct {bit v; bit err; logic [31:0] data; logic [4:0] rd;} rsp_t;
  logic [31:0] ref_mem [DEPTH];
  rsp_t        exp_cur, exp_next;
  bit          exp_ready = 1'b1;
  bit          exp_we = 1'b0;
  logic [31:0] exp_waddr, exp_wd;
  bit          busy = 1'b0;
  int          busy_idx;
  logic [31:0] busy_old, busy_new;
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit model_err(bit we, int f3, logic [31:0] a);
    int size;
    bit illegal;
    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 >= 4);
    size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    return illegal || ((a % size) != 0);
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] w, int lane, int f3);
    logic [31:0] val, half;
    int bytes;
    bytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    if (bytes == 4) return w;
    half = 32'd1 << (8 * bytes - 1);
    val  = (w >> (8 * lane)) % (half * 2);
    if (f3 < 4 && val >= half) val = val - 2 * half;
    return val;
  endfunction

  function automatic logic [31:0] model_merge(logic [31:0] old, logic [31:0] wd, int lane, int f3);
    logic [31:0] mask;
    mask = ((f3 == 0) ? 32'hFF : 32'hFFFF) << (8 * lane);
    return (old & ~mask) | ((wd << (8 * lane)) & mask);
  endfunction

  // One clock cycle of stimulus; the model predicts this cycle's ready/write and next response.
  task automatic drive(bit v, bit we, int f3, logic [31:0] a, logic [31:0] wd, logic [4:0] rd);
    int idx;
    @(posedge clk);
    #1;
    exp_cur    = exp_next;
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3[2:0];
    req_addr   = a;
    req_wdata  = wd;
    req_rd     = rd;
    idx        = (a / 4) % DEPTH;
    exp_ready  = !busy;
    exp_we     = 1'b0;
    exp_next   = '{1'b0, 1'b0, 32'd0, 5'd0};
    if (busy) begin
      exp_we    = 1'b1;
      exp_waddr = busy_idx;
      exp_wd    = busy_new;
      busy      = 1'b0;
    end else if (v) begin
      if (model_err(we, f3, a)) begin
        exp_next = '{1'b1, 1'b1, 32'd0, we ? 5'd0 : rd};
      end else if (!we) begin
        exp_next = '{1'b1, 1'b0, model_load(ref_mem[idx], a % 4, f3), rd};
      end else if (f3 == 2) begin
        exp_we = 1'b1; exp_waddr = idx; exp_wd = wd;
        ref_mem[idx] = wd;
      end else begin
        busy_idx = idx; busy_old = ref_mem[idx];
        busy_new = model_merge(ref_mem[idx], wd, a % 4, f3);
        ref_mem[idx] = busy_new;
        busy = 1'b1;
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic load_lit(string name, int f3, logic [31:0] a, logic [31:0] exp);
    drive(1'b1, 1'b0, f3, a, 32'd0, 5'd7);
    idle();
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({name, "_dut"}, rsp_rdata, exp);
    chk({name, "_model"}, exp_cur.data, exp);
  endtask

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (rst_i) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      if (exp_we) begin
        chk("mem_addr", mem_addr, exp_waddr);
        chk("mem_wd", mem_wd, exp_wd);
      end
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_cur.v});
      if (exp_cur.v) begin
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_cur.err});
        chk("rsp_rdata", rsp_rdata, exp_cur.data);
        chk("rsp_rd", {27'd0, rsp_rd}, {27'd0, exp_cur.rd});
      end
    end
  end

  initial begin
    exp_cur  = '{1'b0, 1'b0, 32'd0, 5'd0};
    exp_next = exp_cur;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_rd", {27'd0, rsp_rd}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 rst_i = 1'b1;

    // Directed loads
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    load_lit("lw",  2, 32'h10, 32'hDEADBEEF);
    load_lit("lb",  0, 32'h13, 32'hFFFFFFDE);
    load_lit("lbu", 4, 32'h13, 32'h000000DE);
    load_lit("lh",  1, 32'h12, 32'hFFFFDEAD);
    load_lit("lhu", 5, 32'h10, 32'h0000BEEF);

    // Sub-word stores back to back
    mem[4] = 32'h11223344; ref_mem[4] = 32'h11223344;
    drive(1'b1, 1'b1, 0, 32'h11, 32'h000000AB, 5'd0);
    idle();
    drive(1'b1, 1'b1, 1, 32'h12, 32'h0000CAFE, 5'd0);
    chk("sb_word", mem[4], 32'h1122AB44);
    idle();
    idle();
    chk("sh_word", mem[4], 32'hCAFEAB44);
    chk("sh_model", ref_mem[4], 32'hCAFEAB44);

    // Misaligned accesses
    drive(1'b1, 1'b0, 2, 32'h12, 32'd0, 5'd3);
    idle();
    @(negedge clk);
    chk("lw_mis_err", {31'd0, rsp_err}, 32'd1);
    chk("lw_mis_data", rsp_rdata, 32'd0);
    drive(1'b1, 1'b1, 2, 32'h11, 32'h12345678, 5'd0);
    idle();
    @(negedge clk);
    chk("sw_mis_err", {31'd0, rsp_err}, 32'd1);
    chk("sw_mis_mem", mem[4], 32'hCAFEAB44);

    // Aligned word store
    drive(1'b1, 1'b1, 2, 32'h20, 32'h0BADF00D, 5'd0);
    idle();
    @(negedge clk);
    chk("sw_word", mem[8], 32'h0BADF00D);
    chk("sw_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // Reset while the RMW write is pending
    mem[5] = 32'h55667788; ref_mem[5] = 32'h55667788;
    drive(1'b1, 1'b1, 0, 32'h14, 32'h00000099, 5'd0);
    idle();
    #1 rst_i = 1'b0;
    #1;
    chk("rst_rmw_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rmw_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rmw_rsp", {rsp_valid, rsp_err, rsp_rd, rsp_rdata[24:0]}, 32'd0);
    busy = 1'b0;
    ref_mem[busy_idx] = busy_old;
    exp_we = 1'b0; exp_ready = 1'b1;
    exp_cur = '{1'b0, 1'b0, 32'd0, 5'd0};
    exp_next = exp_cur;
    @(posedge clk);
    #1 rst_i = 1'b1;
    chk("rst_rmw_word", mem[5], 32'h55667788);

    // Randomized traffic over a small window of words, upper address bits random
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      int f3;
      bit we;
      a = $urandom;
      a[IDX_W+1:6] = '0;
      we = $urandom_range(0, 1);
      f3 = $urandom_range(0, 7);
      if (we && (f3 == 4 || f3 == 5)) f3 = f3 - 4;
      if (($urandom % 4) != 0 && $urandom_range(0, 3) != 0) a[1:0] = (f3 % 4 == 1) ? 2'b10 * a[1] : a[1:0];
      if (f3 % 4 == 2 && ($urandom % 4) != 0) a[1:0] = 2'b00;
      drive($urandom_range(0, 4) != 0, we, f3, a, $urandom, 5'($urandom));
    end
    idle();
    idle();
    @(negedge clk);
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
